ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/mips_pkg.sv | 37 +++
 rtl/ex_alu.sv | 35 +++
 rtl/ex_stage.sv | 147 ++++++++++++++
 tb/tb_ex_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, ALU opcodes, NoC FSM encoding and EX/MEM control payload.
package mips_pkg;

   localparam int unsigned PC_W       = 32;
   localparam int unsigned RADD_W     = 5;
   localparam int unsigned DEST_W     = 2;
   localparam int unsigned ALU_CTRL_W = 4;
   localparam int unsigned SHAMT_W    = 5;
   localparam int unsigned JIMM_W     = 26;
   localparam int unsigned ST_W       = 2;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'b1000;
   localparam logic [ALU_CTRL_W-1:0] ALU_LUI = 4'b1001;

   localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
   localparam logic [ST_W-1:0] ST_SEND = 2'b01;
   localparam logic [ST_W-1:0] ST_DONE = 2'b10;

   // Control bits carried from EX into the EX/MEM register.
   typedef struct packed {
      logic regw;
      logic mem_write;
      logic mem_read;
      logic result_src;
   } exmem_ctrl_t;

   localparam exmem_ctrl_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU for the EX stage; unknown opcodes yield zero.
module ex_alu
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [ALU_CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic [DATA_W-1:0]     y
);

   logic [SHAMT_W-1:0] shamt;

   assign shamt = b[SHAMT_W-1:0];

   // Operation select; all arithmetic wraps, no flags.
   always_comb begin
      y = '0;
      case (alu_ctrl)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
         ALU_SLL: y = a << shamt;
         ALU_SRL: y = a >> shamt;
         ALU_SRA: y = DATA_W'($signed(a) >>> shamt);
         ALU_LUI: y = b << 16;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// EX stage: ALU, branch/jump resolution, NoC injection FSM and EX/MEM register.
module ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  jump_e,
   input  logic                  beq_e,
   input  logic                  bneq_e,
   input  logic                  regw_e,
   input  logic                  alu_src_e,
   input  logic                  mem_write_e,
   input  logic                  mem_read_e,
   input  logic                  result_src_e,
   input  logic [ALU_CTRL_W-1:0] alu_ctrl_e,
   input  logic [DATA_W-1:0]     rd1_e,
   input  logic [DATA_W-1:0]     rd2_e,
   input  logic [PC_W-1:0]       pc_e,
   input  logic [DATA_W-1:0]     imm_e,
   input  logic [RADD_W-1:0]     radd_e,
   input  logic [DEST_W-1:0]     dest_add_e,
   input  logic                  noc_send_e,
   input  logic                  noc_ready,
   output logic                  noc_valid,
   output logic [DEST_W-1:0]     noc_dest,
   output logic [DATA_W-1:0]     noc_data,
   output logic                  stall_o,
   output logic                  redirect,
   output logic [PC_W-1:0]       redirect_pc,
   output logic [DATA_W-1:0]     alu_result_m,
   output logic [DATA_W-1:0]     wdata_m,
   output logic [RADD_W-1:0]     radd_m,
   output logic                  regw_m,
   output logic                  mem_write_m,
   output logic                  mem_read_m,
   output logic                  result_src_m
);

   logic [ST_W-1:0]   state;
   logic [ST_W-1:0]   state_nxt;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_y;
   logic              stall;
   logic              send_start;
   logic              br_taken;
   logic [PC_W-1:0]   pc_plus4;
   logic [PC_W-1:0]   br_target;
   logic [PC_W-1:0]   jmp_target;
   exmem_ctrl_t       ctrl_e;
   exmem_ctrl_t       ctrl_m;

   assign alu_b = alu_src_e ? imm_e : rd2_e;

   ex_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .alu_ctrl (alu_ctrl_e),
      .a        (rd1_e),
      .b        (alu_b),
      .y        (alu_y)
   );

   // Stall while a packet is being launched or is waiting for the router;
   // DONE deliberately ignores noc_send_e so one instruction sends once.
   assign send_start = (state == ST_IDLE) && noc_send_e;
   assign stall      = send_start || (state == ST_SEND);
   assign stall_o    = stall && !rst;
   assign noc_valid  = (state == ST_SEND);

   assign pc_plus4   = pc_e + PC_W'(4);
   assign br_target  = pc_plus4 + (PC_W'(imm_e) << 2);
   assign jmp_target = {pc_plus4[PC_W-1:PC_W-4], imm_e[JIMM_W-1:0], 2'b00};
   assign br_taken   = (beq_e && (rd1_e == rd2_e)) || (bneq_e && (rd1_e != rd2_e));

   // Control-flow redirect; jump wins over branches, suppressed on stall/reset.
   always_comb begin
      redirect    = 1'b0;
      redirect_pc = br_target;
      if (!rst && !stall) begin
         if (jump_e) begin
            redirect    = 1'b1;
            redirect_pc = jmp_target;
         end else if (br_taken) begin
            redirect    = 1'b1;
         end
      end
   end

   // NoC FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NoC FSM next-state: IDLE -> SEND -> DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (noc_send_e) state_nxt = ST_SEND;
         ST_SEND: if (noc_ready)  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Packet payload captured on launch and held through SEND.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         noc_dest <= '0;
         noc_data <= '0;
      end else if (send_start) begin
         noc_dest <= dest_add_e;
         noc_data <= alu_y;
      end
   end

   assign ctrl_e = '{regw:       regw_e,
                     mem_write:  mem_write_e,
                     mem_read:   mem_read_e,
                     result_src: result_src_e};

   // EX/MEM register; a stall injects a bubble by zeroing the controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result_m <= '0;
         wdata_m      <= '0;
         radd_m       <= '0;
         ctrl_m       <= EXMEM_BUBBLE;
      end else begin
         alu_result_m <= alu_y;
         wdata_m      <= rd2_e;
         radd_m       <= radd_e;
         ctrl_m       <= stall ? EXMEM_BUBBLE : ctrl_e;
      end
   end

   assign regw_m       = ctrl_m.regw;
   assign mem_write_m  = ctrl_m.mem_write;
   assign mem_read_m   = ctrl_m.mem_read;
   assign result_src_m = ctrl_m.result_src;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboarded EX/MEM, redirect and NoC checks.
module tb_ex_stage;

   logic        clk;
   logic        rst;
   logic        jump_e, beq_e, bneq_e, regw_e, alu_src_e;
   logic        mem_write_e, mem_read_e, result_src_e;
   logic [3:0]  alu_ctrl_e;
   logic [31:0] rd1_e, rd2_e, pc_e, imm_e;
   logic [4:0]  radd_e;
   logic [1:0]  dest_add_e;
   logic        noc_send_e;
   logic        noc_ready;
   logic        noc_valid;
   logic [1:0]  noc_dest;
   logic [31:0] noc_data;
   logic        stall_o;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] alu_result_m, wdata_m;
   logic [4:0]  radd_m;
   logic        regw_m, mem_write_m, mem_read_m, result_src_m;

   typedef struct packed {
      logic        bubble;
      logic        regw;
      logic        mw;
      logic        mr;
      logic        rs;
      logic [31:0] res;
      logic [31:0] wd;
      logic [4:0]  radd;
   } exp_t;

   exp_t sb[$];
   int   total;
   int   bad;
   int   pkts;

   ex_stage #(
      .DATA_W (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .jump_e       (jump_e),
      .beq_e        (beq_e),
      .bneq_e       (bneq_e),
      .regw_e       (regw_e),
      .alu_src_e    (alu_src_e),
      .mem_write_e  (mem_write_e),
      .mem_read_e   (mem_read_e),
      .result_src_e (result_src_e),
      .alu_ctrl_e   (alu_ctrl_e),
      .rd1_e        (rd1_e),
      .rd2_e        (rd2_e),
      .pc_e         (pc_e),
      .imm_e        (imm_e),
      .radd_e       (radd_e),
      .dest_add_e   (dest_add_e),
      .noc_send_e   (noc_send_e),
      .noc_ready    (noc_ready),
      .noc_valid    (noc_valid),
      .noc_dest     (noc_dest),
      .noc_data     (noc_data),
      .stall_o      (stall_o),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .alu_result_m (alu_result_m),
      .wdata_m      (wdata_m),
      .radd_m       (radd_m),
      .regw_m       (regw_m),
      .mem_write_m  (mem_write_m),
      .mem_read_m   (mem_read_m),
      .result_src_m (result_src_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference ALU written from the opcode table.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return a << sh;
         4'd7:    return a >> sh;
         4'd8:    return 32'($signed(a) >>> sh);
         4'd9:    return b << 16;
         default: return 32'd0;
      endcase
   endfunction

   task automatic clear_instr();
      jump_e = 0; beq_e = 0; bneq_e = 0; regw_e = 0; alu_src_e = 0;
      mem_write_e = 0; mem_read_e = 0; result_src_e = 0;
      alu_ctrl_e = 4'd0; rd1_e = 0; rd2_e = 0; pc_e = 0; imm_e = 0;
      radd_e = 0; dest_add_e = 0; noc_send_e = 0;
   endtask

   // One EX cycle: check combinational outputs mid-cycle, push the expected
   // EX/MEM contents, then pop and compare them just after the clock edge.
   task automatic run_cycle(input logic exp_stall, input logic exp_nv,
                            input logic [31:0] exp_ndata, input logic [1:0] exp_ndest);
      exp_t        e;
      exp_t        got;
      logic        taken;
      logic [31:0] pc4;
      logic [31:0] tgt;
      @(negedge clk);
      check("stall_o", 32'(stall_o), 32'(exp_stall));
      check("noc_valid", 32'(noc_valid), 32'(exp_nv));
      if (exp_nv) begin
         check("noc_data", noc_data, exp_ndata);
         check("noc_dest", 32'(noc_dest), 32'(exp_ndest));
      end
      if (noc_valid && noc_ready) pkts++;
      pc4 = pc_e + 32'd4;
      if (jump_e) begin
         taken = 1'b1;
         tgt   = {pc4[31:28], imm_e[25:0], 2'b00};
      end else begin
         taken = (beq_e && (rd1_e == rd2_e)) || (bneq_e && (rd1_e != rd2_e));
         tgt   = pc4 + (imm_e << 2);
      end
      if (exp_stall) taken = 1'b0;
      check("redirect", 32'(redirect), 32'(taken));
      if (taken) check("redirect_pc", redirect_pc, tgt);
      e = '0;
      e.bubble = exp_stall;
      if (!exp_stall) begin
         e.regw = regw_e; e.mw = mem_write_e; e.mr = mem_read_e; e.rs = result_src_e;
         e.res  = ref_alu(alu_ctrl_e, rd1_e, alu_src_e ? imm_e : rd2_e);
         e.wd   = rd2_e;
         e.radd = radd_e;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check("m_regw", 32'(regw_m), 32'(got.regw));
         check("m_mem_write", 32'(mem_write_m), 32'(got.mw));
         check("m_mem_read", 32'(mem_read_m), 32'(got.mr));
         check("m_result_src", 32'(result_src_m), 32'(got.rs));
         if (!got.bubble) begin
            check("m_alu_result", alu_result_m, got.res);
            check("m_wdata", wdata_m, got.wd);
            check("m_radd", 32'(radd_m), 32'(got.radd));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0; bad = 0; pkts = 0;
      clear_instr();
      rst = 1'b1;
      noc_ready = 1'b1;
      // Reset state with provoking inputs.
      noc_send_e = 1; beq_e = 1; rd1_e = 9; rd2_e = 9; regw_e = 1;
      #12;
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_redirect", 32'(redirect), 32'd0);
      check("rst_noc_valid", 32'(noc_valid), 32'd0);
      check("rst_noc_data", noc_data, 32'd0);
      check("rst_alu_result_m", alu_result_m, 32'd0);
      check("rst_regw_m", 32'(regw_m), 32'd0);
      clear_instr();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ADD 7+5 immediate.
      alu_ctrl_e = 4'd0; rd1_e = 7; imm_e = 5; alu_src_e = 1; regw_e = 1; radd_e = 3;
      run_cycle(0, 0, 0, 0);
      check("add_result", alu_result_m, 32'd12);
      check("add_regw", 32'(regw_m), 32'd1);

      clear_instr();
      alu_ctrl_e = 4'd1; rd1_e = 3; rd2_e = 5; regw_e = 1;
      run_cycle(0, 0, 0, 0);
      check("sub_result", alu_result_m, 32'hFFFF_FFFE);

      alu_ctrl_e = 4'd5; rd1_e = 32'hFFFF_FFFF; rd2_e = 1;
      run_cycle(0, 0, 0, 0);
      check("slt_result", alu_result_m, 32'd1);

      alu_ctrl_e = 4'd8; rd1_e = 32'h8000_0000; imm_e = 4; alu_src_e = 1;
      run_cycle(0, 0, 0, 0);
      check("sra_result", alu_result_m, 32'hF800_0000);

      // Random sweep over every opcode; noc_ready toggles with no effect.
      for (int i = 0; i < 48; i++) begin
         alu_ctrl_e   = 4'(i);
         rd1_e        = $urandom;
         rd2_e        = (i % 5 == 0) ? rd1_e : $urandom;
         imm_e        = $urandom;
         pc_e         = $urandom;
         alu_src_e    = 1'($urandom_range(1, 0));
         regw_e       = 1'($urandom_range(1, 0));
         mem_write_e  = 1'($urandom_range(1, 0));
         mem_read_e   = 1'($urandom_range(1, 0));
         result_src_e = 1'($urandom_range(1, 0));
         beq_e        = 1'($urandom_range(1, 0));
         bneq_e       = 1'($urandom_range(1, 0));
         jump_e       = (i % 7 == 3);
         radd_e       = 5'($urandom);
         noc_ready    = 1'($urandom_range(1, 0));
         run_cycle(0, 0, 0, 0);
      end

      // Branch and jump redirects.
      clear_instr();
      beq_e = 1; rd1_e = 9; rd2_e = 9; pc_e = 32'h100; imm_e = 3;
      #1;
      check("beq_redirect", 32'(redirect), 32'd1);
      check("beq_target", redirect_pc, 32'h110);
      run_cycle(0, 0, 0, 0);
      beq_e = 0; bneq_e = 1;
      #1;
      check("bneq_redirect", 32'(redirect), 32'd0);
      run_cycle(0, 0, 0, 0);
      bneq_e = 0; beq_e = 1; jump_e = 1; pc_e = 32'h3FFF_FFFC; imm_e = 32'h0012_3456;
      #1;
      check("jump_target", redirect_pc, 32'h4048_D158);
      run_cycle(0, 0, 0, 0);

      // NoC send with router busy for 4 SEND cycles.
      clear_instr();
      noc_ready = 0; pkts = 0;
      alu_ctrl_e = 4'd0; rd1_e = 32'hABC0; imm_e = 32'hD; alu_src_e = 1;
      regw_e = 1; radd_e = 7; noc_send_e = 1; dest_add_e = 2;
      beq_e = 1; rd2_e = 32'hABC0;
      run_cycle(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) run_cycle(1, 1, 32'hABCD, 2'd2);
      noc_ready = 1;
      run_cycle(1, 1, 32'hABCD, 2'd2);
      run_cycle(0, 0, 0, 0);
      check("noc_wb_result", alu_result_m, 32'hABCD);
      check("noc_wb_regw", 32'(regw_m), 32'd1);
      clear_instr();
      alu_ctrl_e = 4'd3; rd1_e = 32'h10; rd2_e = 32'h01;
      run_cycle(0, 0, 0, 0);
      check("noc_pkts_slow", 32'(pkts), 32'd1);

      // NoC send with router always ready.
      clear_instr();
      noc_ready = 1; pkts = 0;
      alu_ctrl_e = 4'd1; rd1_e = 32'h100; rd2_e = 1; regw_e = 1; radd_e = 9;
      noc_send_e = 1; dest_add_e = 1;
      run_cycle(1, 0, 0, 0);
      run_cycle(1, 1, 32'hFF, 2'd1);
      run_cycle(0, 0, 0, 0);
      clear_instr();
      alu_ctrl_e = 4'd9; imm_e = 32'h1234; alu_src_e = 1; regw_e = 1;
      run_cycle(0, 0, 0, 0);
      check("lui_result", alu_result_m, 32'h1234_0000);
      check("noc_pkts_fast", 32'(pkts), 32'd1);

      // Reset asserted in the middle of SEND abandons the packet.
      clear_instr();
      noc_ready = 0;
      alu_ctrl_e = 4'd0; rd1_e = 32'h11; regw_e = 1; noc_send_e = 1; dest_add_e = 3;
      run_cycle(1, 0, 0, 0);
      #1;
      check("pre_rst_valid", 32'(noc_valid), 32'd1);
      rst = 1'b1;
      jump_e = 1;
      #1;
      check("mid_rst_valid", 32'(noc_valid), 32'd0);
      check("mid_rst_stall", 32'(stall_o), 32'd0);
      check("mid_rst_redirect", 32'(redirect), 32'd0);
      check("mid_rst_alu_m", alu_result_m, 32'd0);
      check("mid_rst_regw_m", 32'(regw_m), 32'd0);
      check("mid_rst_noc_data", noc_data, 32'd0);
      check("mid_rst_noc_dest", 32'(noc_dest), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_instr();
      @(posedge clk);
      #1;
      pkts = 0; noc_ready = 1;
      alu_ctrl_e = 4'd0; rd1_e = 32'h55; regw_e = 1; noc_send_e = 1; dest_add_e = 1;
      run_cycle(1, 0, 0, 0);
      run_cycle(1, 1, 32'h55, 2'd1);
      run_cycle(0, 0, 0, 0);
      check("post_rst_pkts", 32'(pkts), 32'd1);
      clear_instr();
      run_cycle(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
